// File: rtl/simple_proc_controller.sv
// Multi-cycle fetch/decode/execute/write-back controller feeding a 4-bit ALU.
// Owns an NREGS x 4-bit register file with a combinational debug read port.
module simple_proc_controller #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned PCW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     instr_valid,
    input  logic [11:0]              instr,
    output logic                     instr_ready,
    output logic [PCW-1:0]           pc,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [1:0]               alu_s,
    input  logic [3:0]               alu_res,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [3:0]               dbg_data,
    output logic                     busy,
    output logic                     halted
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned DW = 4;
    localparam int unsigned IW = 12;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_ADD  = 2'd1;
    localparam logic [1:0] SEL_SUB  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALTED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ir;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic [DW-1:0]   wbdata;
    logic [DW-1:0]   regs [NREGS];
    logic [1:0]      alu_s_nxt;

    logic [1:0]      ir_op;
    logic [AW-1:0]   ir_rd;
    logic [AW-1:0]   ir_ra;
    logic [AW-1:0]   ir_rb;
    logic [DW-1:0]   ir_imm;

    assign ir_op  = ir[11:10];
    assign ir_rd  = ir[9:7];
    assign ir_ra  = ir[6:4];
    assign ir_rb  = ir[3:1];
    assign ir_imm = ir[3:0];

    assign alu_a    = opa;
    assign alu_b    = opb;
    assign dbg_data = regs[dbg_addr];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-cycle select decode
    always_comb begin
        state_nxt = state;
        alu_s_nxt = SEL_ZERO;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (instr_valid) state_nxt = DECODE;
            DECODE: begin
                case (ir_op)
                    OP_LDI:  state_nxt = WB;
                    OP_ADD,
                    OP_SUB:  state_nxt = EXEC;
                    default: state_nxt = HALTED;
                endcase
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = FETCH;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == EXEC) begin
            alu_s_nxt = (ir_op == OP_ADD) ? SEL_ADD : SEL_SUB;
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_ready <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            alu_s       <= SEL_ZERO;
        end else begin
            instr_ready <= (state_nxt == FETCH);
            busy        <= (state_nxt != IDLE) && (state_nxt != HALTED);
            halted      <= (state_nxt == HALTED);
            alu_s       <= alu_s_nxt;
        end
    end

    // Datapath: instruction, operands, write-back data, pc
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            wbdata <= '0;
            pc     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir <= instr;
                        pc <= pc + PCW'(1);
                    end
                end
                DECODE: begin
                    opa <= regs[ir_ra];
                    opb <= regs[ir_rb];
                    if (ir_op == OP_LDI) wbdata <= ir_imm;
                end
                EXEC:    wbdata <= alu_res;
                default: ;
            endcase
        end
    end

    // Register file; reset clears it so an aborted instruction leaves nothing behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == WB) begin
            regs[ir_rd] <= wbdata;
        end
    end

endmodule

// File: tb/tb_simple_proc_controller.sv
// Bench for simple_proc_controller: instruction-level reference model with
// a behavioural ALU attached to the controller's operand/select outputs.
module tb_simple_proc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic [11:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  pc;
    logic [3:0]  alu_a, alu_b;
    logic [1:0]  alu_s;
    logic [3:0]  alu_res;
    logic [2:0]  dbg_addr = '0;
    logic [3:0]  dbg_data;
    logic        busy, halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] mdl_regs [8];
    logic [3:0] mdl_pc;

    always #10 clk = ~clk;

    assign alu_res = (alu_s == 2'd1) ? 4'(alu_a + alu_b) :
                     (alu_s == 2'd2) ? 4'(alu_a - alu_b) : 4'd0;

    simple_proc_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .pc(pc), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_res(alu_res),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .halted(halted)
    );

    function automatic logic [11:0] enc_ldi(input logic [2:0] rd, input logic [3:0] imm);
        return {2'b00, rd, 3'b000, imm};
    endfunction

    function automatic logic [11:0] enc_alu(input logic [1:0] op, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 1'b0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mdl_regs[i] = 4'd0;
        mdl_pc = 4'd0;
    endtask

    // Reads every register through the debug port against the model
    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            n_tests++;
            if (dbg_data !== mdl_regs[r]) begin
                n_fail++;
                $display("FAIL %s reg%0d: got %0d expected %0d", tag, r, dbg_data, mdl_regs[r]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issues one instruction from FETCH and checks timing, ALU drive, pc and registers
    task automatic exec_instr(input logic [11:0] w);
        logic [1:0] op;
        logic [3:0] ea, eb;
        int lat, nexec, exp_lat, exp_exec;
        op = w[11:10];
        ea = mdl_regs[w[6:4]];
        eb = mdl_regs[w[3:1]];
        n_tests++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_ready: instr_ready=%b expected 1", instr_ready);
        end
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 12'($urandom);
        lat = 1;
        nexec = 0;
        while (instr_ready !== 1'b1 && halted !== 1'b1 && lat < 20) begin
            if (alu_s !== 2'd0) begin
                nexec++;
                n_tests++;
                if (alu_s !== op || alu_a !== ea || alu_b !== eb) begin
                    n_fail++;
                    $display("FAIL exec_drive: s/a/b=%0d/%0d/%0d expected %0d/%0d/%0d",
                             alu_s, alu_a, alu_b, op, ea, eb);
                end
            end
            @(negedge clk);
            lat++;
        end
        mdl_pc = 4'(mdl_pc + 4'd1);
        case (op)
            2'b00: begin mdl_regs[w[9:7]] = w[3:0]; exp_lat = 3; exp_exec = 0; end
            2'b01: begin mdl_regs[w[9:7]] = 4'(ea + eb); exp_lat = 4; exp_exec = 1; end
            2'b10: begin mdl_regs[w[9:7]] = 4'(ea - eb); exp_lat = 4; exp_exec = 1; end
            default: begin exp_lat = 2; exp_exec = 0; end
        endcase
        n_tests++;
        if (lat != exp_lat || nexec != exp_exec) begin
            n_fail++;
            $display("FAIL latency op%0d: cycles=%0d exec=%0d expected %0d/%0d",
                     op, lat, nexec, exp_lat, exp_exec);
        end
        n_tests++;
        if (pc !== mdl_pc) begin
            n_fail++;
            $display("FAIL pc: got %0d expected %0d", pc, mdl_pc);
        end
        check_regs("after_instr");
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (instr_ready !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || alu_s !== 2'd0 ||
            alu_a !== 4'd0 || alu_b !== 4'd0 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b busy=%b halt=%b s=%0d a=%0d b=%0d pc=%0d expected all 0",
                     instr_ready, busy, halted, alu_s, alu_a, alu_b, pc);
        end
        model_clear();
        check_regs("reset");
        do_reset();
        do_start();
        n_tests++;
        if (busy !== 1'b1 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start: busy=%b rdy=%b expected 1/1", busy, instr_ready);
        end
    endtask

    task automatic test_ldi();
        exec_instr(enc_ldi(3'd1, 4'd5));
        exec_instr(enc_ldi(3'd2, 4'd3));
        n_tests++;
        if (pc !== 4'd2) begin
            n_fail++;
            $display("FAIL ldi_pc: got %0d expected 2", pc);
        end
    endtask

    task automatic test_alu();
        exec_instr(enc_alu(2'b01, 3'd3, 3'd1, 3'd2));
        exec_instr(enc_alu(2'b10, 3'd4, 3'd2, 3'd1));
        dbg_addr = 3'd3;
        #1;
        n_tests++;
        if (dbg_data !== 4'd8) begin
            n_fail++;
            $display("FAIL add_r3: got %0d expected 8", dbg_data);
        end
        dbg_addr = 3'd4;
        #1;
        n_tests++;
        if (dbg_data !== 4'd14) begin
            n_fail++;
            $display("FAIL sub_r4: got %0d expected 14", dbg_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        do_start();
        exec_instr(enc_ldi(3'd1, 4'd9));
        exec_instr(enc_alu(2'b01, 3'd1, 3'd1, 3'd1));
        dbg_addr = 3'd1;
        #1;
        n_tests++;
        if (dbg_data !== 4'd2) begin
            n_fail++;
            $display("FAIL wrap_add: got %0d expected 2", dbg_data);
        end
        do_reset();
        do_start();
        for (int i = 1; i <= 17; i++) begin
            exec_instr(enc_ldi(3'($urandom_range(0, 7)), 4'($urandom)));
            if (i == 16 || i == 17) begin
                n_tests++;
                if (pc !== 4'(i - 16)) begin
                    n_fail++;
                    $display("FAIL pc_wrap fetch%0d: got %0d expected %0d", i, pc, i - 16);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] w;
        do_reset();
        do_start();
        for (int i = 0; i < 40; i++) begin
            w = 12'($urandom);
            w[11:10] = 2'($urandom_range(0, 2));
            exec_instr(w);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr = enc_ldi(3'd0, 4'hF);
            n_tests++;
            if (instr_ready !== 1'b1 || pc !== mdl_pc || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall%0d: rdy=%b pc=%0d busy=%b expected 1/%0d/1",
                         i, instr_ready, pc, busy, mdl_pc);
            end
            @(negedge clk);
        end
        check_regs("stall");
        exec_instr(enc_ldi(3'd0, 4'd7));
    endtask

    task automatic test_halt();
        logic [3:0] pc_h;
        exec_instr(12'b11_000_000_000_0);
        pc_h = mdl_pc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = (i == 1);
            instr_valid = 1'b1;
            instr = enc_ldi(3'd5, 4'd9);
            n_tests++;
            if (halted !== 1'b1 || busy !== 1'b0 || instr_ready !== 1'b0 || pc !== pc_h) begin
                n_fail++;
                $display("FAIL halt%0d: halted=%b busy=%b rdy=%b pc=%0d expected 1/0/0/%0d",
                         i, halted, busy, instr_ready, pc, pc_h);
            end
        end
        start = 1'b0;
        instr_valid = 1'b0;
        check_regs("halted");
    endtask

    task automatic test_reset_exec();
        int n;
        do_reset();
        do_start();
        exec_instr(enc_ldi(3'd1, 4'd5));
        exec_instr(enc_ldi(3'd2, 4'd3));
        instr = enc_alu(2'b01, 3'd3, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (alu_s === 2'd0 && n < 6) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (alu_s !== 2'd1) begin
            n_fail++;
            $display("FAIL reach_exec: alu_s=%0d expected 1", alu_s);
        end
        reset = 1'b1;
        #1;
        model_clear();
        n_tests++;
        if (alu_s !== 2'd0 || pc !== 4'd0 || busy !== 1'b0 || instr_ready !== 1'b0 ||
            halted !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: s=%0d pc=%0d busy=%b rdy=%b halt=%b expected 0",
                     alu_s, pc, busy, instr_ready, halted);
        end
        check_regs("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL post_abort_idle: busy=%b rdy=%b expected 0/0", busy, instr_ready);
        end
        check_regs("post_abort");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ldi();
        test_alu();
        test_stall();
        test_wrap();
        test_random();
        test_halt();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_proc_controller.md
Name: simple_proc_controller

Overview:
- Multi-cycle control and register stage that sits directly upstream of the 4-bit ALU and also receives the ALU's result.
- Fetches 12-bit instructions through a valid/ready handshake and decodes them.
- Reads operands from an internal 8x4-bit register file and drives the ALU operand inputs (a, b) and select input (s).
- Captures the ALU result and writes it back to the register file.

Parameters:
- NREGS, 8, number of 4-bit registers; register address width is log2(NREGS) = 3.
- PCW, 4, program counter width; the counter wraps modulo 2^PCW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from IDLE.
- instr_valid  in  1  instruction source has a valid word on instr.
- instr  in  12  instruction word.
- instr_ready  out  1  controller is ready to accept instr.
- pc  out  PCW  address of the next instruction to fetch.
- alu_a  out  4  ALU operand a.
- alu_b  out  4  ALU operand b.
- alu_s  out  2  ALU select: 0 = zero, 1 = add, 2 = sub.
- alu_res  in  4  ALU combinational result.
- dbg_addr  in  3  debug register read address.
- dbg_data  out  4  contents of reg[dbg_addr], combinational read.
- busy  out  1  high in any state other than IDLE or HALTED.
- halted  out  1  high in the HALTED state.

Behaviour:
- Reset (asynchronous) sets the following; a reset asserted in any state, mid-instruction included, aborts that instruction with no write-back:
  - state = IDLE, pc = 0, all registers = 0;
  - IR, operand registers and write-back data register = 0;
  - instr_ready = 0, alu_s = 0, alu_a = alu_b = 0, busy = 0, halted = 0.
- Instruction format:
  - [11:10] op: 00 LDI, 01 ADD, 10 SUB, 11 HALT.
  - [9:7] rd, [6:4] ra, [3:1] rb.
  - LDI uses imm = [3:0]; bits not used by an op are ignored.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE: start = 1 -> FETCH; otherwise stay.
  - FETCH: instr_ready = 1 (this is the only state where it is high).
    - On instr_valid & instr_ready at a clock edge: latch IR, pc <= pc + 1 (wraps 15 -> 0), go to DECODE.
    - With no valid: wait indefinitely; pc does not change.
  - DECODE: latch opA = reg[ra] and opB = reg[rb]; then branch on op:
    - LDI: wbdata <= imm, go to WB.
    - ADD/SUB: go to EXEC.
    - HALT: go to HALTED.
  - EXEC: alu_s = 1 (ADD) or 2 (SUB); wbdata <= alu_res at the edge; go to WB.
  - WB: reg[rd] <= wbdata; go to FETCH.
  - HALTED: stay until reset; start is ignored.
- ALU outputs:
  - alu_a = opA and alu_b = opB at all times.
  - alu_s = 0 in every state except EXEC.
- Arithmetic is 4-bit modulo 16; carry and borrow are discarded.
  - Example: 9 + 9 = 2; 3 - 5 = 14.
- Operand read and write-back:
  - Operands are read in DECODE, so they reflect all prior write-backs. No hazards, because only one instruction is in flight.
  - rd equal to ra or rb is allowed: the old value is used and the new value is written.
- Latency:
  - LDI: 3 cycles from the handshake edge to the next FETCH.
  - ADD/SUB: 4 cycles.
  - Written data appears on dbg_data the cycle after the WB edge.
- start while busy is ignored.
- All 8 registers, including reg 0, are writable.

Test Plan:
1. Reset, pulse start, feed LDI r1,#5 then LDI r2,#3 with instr_valid held high -> dbg r1 = 5, r2 = 3; pc = 2; instr_ready high for exactly one cycle per fetch.
2. After test 1, feed ADD r3,r1,r2 then SUB r4,r2,r1 -> during each EXEC cycle alu_s = 1 then 2, with alu_a/alu_b = 5/3 then 3/5; r3 = 8, r4 = 14.
3. Wrap-around: load r1 = 9, then ADD r1,r1,r1 -> r1 = 2. Also fetch 17 instructions and check pc goes 15 -> 0 -> 1.
4. Hold instr_valid low for 5 cycles in FETCH -> instr_ready stays 1, pc and registers unchanged, no write-back. Then raise valid -> instruction accepted on that edge.
5. HALT -> halted = 1, busy = 0 and instr_ready = 0 permanently; a start pulse and instr_valid have no effect.
6. Assert reset during the EXEC cycle of an ADD -> immediately: state IDLE, alu_s = 0, pc = 0, all registers read 0, and rd is not written.
